// File: rtl/freq_pkg.sv
// ---------------------------------------------------------------------------
// freq_pkg
// Shared constants and types for the frequency generator / meter pair.
//   FREQ_CLK_HZ : default system clock rate in Hz (shared with freq_meter)
//   FREQ_W_DFLT : default width of a frequency request in Hz
//   gen_state_e : generator control states IDLE / RUN / STOPPING
// ---------------------------------------------------------------------------
package freq_pkg;

    localparam int FREQ_CLK_HZ = 100_000_000;
    localparam int FREQ_W_DFLT = 16;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        STOPPING = 2'd2
    } gen_state_e;

endpackage

// File: rtl/freq_gen_nco.sv
// ---------------------------------------------------------------------------
// freq_gen_nco
// Phase accumulator that produces one toggle request each time the
// accumulated phase crosses CLK_HZ. The modulo is a subtraction, not a
// divider: the step never exceeds CLK_HZ, so at most one wrap per cycle.
// Ports:
//   clk, rst : system clock, asynchronous active-low reset
//   run      : accumulate this cycle; when low the accumulator is cleared
//   step     : phase increment per cycle (2 * frequency in Hz)
//   toggle   : combinational, high in the cycle the phase wraps
//   acc_clr  : accumulator currently holds zero
// ---------------------------------------------------------------------------
module freq_gen_nco
    import freq_pkg::*;
#(
    parameter int CLK_HZ = FREQ_CLK_HZ,
    parameter int ACC_W  = 28,
    parameter int STEP_W = FREQ_W_DFLT + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    input  logic [STEP_W-1:0] step,
    output logic              toggle,
    output logic              acc_clr
);

    localparam logic [ACC_W-1:0] MODULUS = ACC_W'(CLK_HZ);

    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] sum;

    always_comb begin
        sum    = acc + ACC_W'(step);
        toggle = run && (sum >= MODULUS);
    end

    assign acc_clr = (acc == '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc <= '0;
        end else if (!run) begin
            acc <= '0;
        end else if (sum >= MODULUS) begin
            acc <= sum - MODULUS;
        end else begin
            acc <= sum;
        end
    end

endmodule

// File: rtl/freq_gen.sv
// ---------------------------------------------------------------------------
// freq_gen
// Programmable square-wave generator. signal_out runs at freq_cur Hz, built
// from the system clock with a phase accumulator. New frequencies captured
// by load are applied only on a falling edge of signal_out while running
// (or one cycle after capture while idle), so every period completes.
// Optional build macro: FREQ_GEN_BURST_EN adds burst_len / done for a
// fixed number of periods per run.
// Ports:
//   clk, rst   : system clock, asynchronous active-low reset
//   en         : run request (level)
//   freq_set   : requested frequency in Hz (0 legal)
//   load       : one-cycle strobe capturing freq_set
//   burst_len  : (burst build) periods per run, 0 = continuous
//   done       : (burst build) one-cycle pulse when a burst finishes
//   busy       : a captured frequency is waiting to be applied
//   signal_out : generated square wave (registered)
//   active     : high in RUN or STOPPING
//   edge_cnt   : rising edges of signal_out since reset, wrapping
// ---------------------------------------------------------------------------
module freq_gen
    import freq_pkg::*;
#(
    parameter int CLK_HZ = FREQ_CLK_HZ,
    parameter int FREQ_W = FREQ_W_DFLT,
    parameter int ACC_W  = 28
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [FREQ_W-1:0] freq_set,
    input  logic              load,
`ifdef FREQ_GEN_BURST_EN
    input  logic [15:0]       burst_len,
    output logic              done,
`endif
    output logic              busy,
    output logic              signal_out,
    output logic              active,
    output logic [15:0]       edge_cnt
);

    localparam longint MAX_STEP = 2 * ((longint'(1) << FREQ_W) - 1);

    // A step larger than CLK_HZ could wrap twice per cycle; an accumulator
    // too narrow could overflow before the wrap subtraction.
    if (longint'(CLK_HZ) < MAX_STEP) begin : g_chk_clk
        $error("freq_gen: CLK_HZ must be >= 2*(2^FREQ_W-1)");
    end
    if ((longint'(1) << ACC_W) <= longint'(CLK_HZ) + MAX_STEP) begin : g_chk_acc
        $error("freq_gen: ACC_W too small for CLK_HZ and FREQ_W");
    end

    gen_state_e        state;
    logic [FREQ_W-1:0] freq_cur;
    logic [FREQ_W-1:0] freq_pend;
    logic              cap_idle;     // pending value was captured while idle
    logic              run_cyc;
    logic              toggle;
    logic              acc_clr;
    logic              fall;
    logic              rise;
    logic              apply;
    logic              start_ok;
    logic              burst_end;

    // Dropping en while low stops immediately; otherwise the high phase
    // keeps accumulating so it completes before IDLE.
    always_comb begin
        run_cyc = ((state == RUN) && (en || signal_out)) || (state == STOPPING);
        fall    = toggle && signal_out;
        rise    = toggle && !signal_out;
        apply   = busy && ((state == IDLE) || cap_idle || fall);
    end

    freq_gen_nco #(
        .CLK_HZ (CLK_HZ),
        .ACC_W  (ACC_W),
        .STEP_W (FREQ_W + 1)
    ) u_nco (
        .clk     (clk),
        .rst     (rst),
        .run     (run_cyc),
        .step    ({freq_cur, 1'b0}),
        .toggle  (toggle),
        .acc_clr (acc_clr)
    );

`ifdef FREQ_GEN_BURST_EN
    logic [15:0] burst_n;
    logic [15:0] rise_cnt;
    logic        hold;           // burst finished, wait for en to drop

    assign burst_end = fall && (burst_n != 16'd0) && (rise_cnt >= burst_n);
    assign start_ok  = en && acc_clr && !hold;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            burst_n  <= '0;
            rise_cnt <= '0;
            hold     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= burst_end;
            if ((state == IDLE) && start_ok) begin
                burst_n  <= burst_len;
                rise_cnt <= '0;
            end else if (rise) begin
                rise_cnt <= rise_cnt + 16'd1;
            end
            if (burst_end) begin
                hold <= 1'b1;
            end else if (!en) begin
                hold <= 1'b0;
            end
        end
    end
`else
    assign burst_end = 1'b0;
    assign start_ok  = en && acc_clr;
`endif

    // Load / pending handling. A load coinciding with an apply leaves the
    // new value pending: the apply takes the old freq_pend.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            freq_cur  <= '0;
            freq_pend <= '0;
            busy      <= 1'b0;
            cap_idle  <= 1'b0;
        end else begin
            if (apply) begin
                freq_cur <= freq_pend;
            end
            if (load) begin
                freq_pend <= freq_set;
                busy      <= 1'b1;
                cap_idle  <= (state == IDLE);
            end else begin
                cap_idle <= 1'b0;
                if (apply) begin
                    busy <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            signal_out <= 1'b0;
            edge_cnt   <= '0;
        end else begin
            if (toggle) begin
                signal_out <= !signal_out;
            end
            if (rise) begin
                edge_cnt <= edge_cnt + 16'd1;
            end
        end
    end

    // Control FSM. Entry to RUN waits for a cleared accumulator so every
    // run starts from zero phase after a stop mid-period.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            active <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_ok) begin
                        state  <= RUN;
                        active <= 1'b1;
                    end
                end
                RUN: begin
                    if (burst_end || (!en && (!signal_out || fall))) begin
                        state  <= IDLE;
                        active <= 1'b0;
                    end else if (!en) begin
                        state <= STOPPING;
                    end
                end
                STOPPING: begin
                    if (burst_end || (!en && fall)) begin
                        state  <= IDLE;
                        active <= 1'b0;
                    end else if (en) begin
                        state <= RUN;
                    end
                end
                default: begin
                    state  <= IDLE;
                    active <= 1'b0;
                end
            endcase
        end
    end

endmodule
